// File: rtl/sw_fnd_pkg.sv
// Shared constants for the stopwatch FND scan controller: segment codes,
// digit count, blank pattern and a field saturation helper.
package sw_fnd_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    // Active-low segment patterns, bit7 = dp (off), bits[6:0] = g..a
    localparam logic [7:0] FND_OFF = 8'hFF;
    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;

    localparam logic [6:0] MAX_FIELD = 7'd99;

    // Digit position: index 0 is the rightmost digit
    typedef enum logic [1:0] {
        DigLoOnes = 2'd0,
        DigLoTens = 2'd1,
        DigHiOnes = 2'd2,
        DigHiTens = 2'd3
    } digit_e;

    // Clamp a field to two decimal digits
    function automatic logic [6:0] sat99(input logic [6:0] v);
        return (v > MAX_FIELD) ? MAX_FIELD : v;
    endfunction

endpackage

// File: rtl/sw_fnd_dec.sv
// BCD to active-low 7-segment decoder (g..a). Codes above 9 blank the digit.
module sw_fnd_dec
    import sw_fnd_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pure lookup; dp is handled by the caller
    always_comb begin
        seg_o = FND_OFF[6:0];
        case (bcd_i)
            4'd0:    seg_o = SEG_0[6:0];
            4'd1:    seg_o = SEG_1[6:0];
            4'd2:    seg_o = SEG_2[6:0];
            4'd3:    seg_o = SEG_3[6:0];
            4'd4:    seg_o = SEG_4[6:0];
            4'd5:    seg_o = SEG_5[6:0];
            4'd6:    seg_o = SEG_6[6:0];
            4'd7:    seg_o = SEG_7[6:0];
            4'd8:    seg_o = SEG_8[6:0];
            4'd9:    seg_o = SEG_9[6:0];
            default: seg_o = FND_OFF[6:0];
        endcase
    end

endmodule

// File: rtl/sw_fnd_ctrl.sv
// Four-digit multiplexed FND driver for a stopwatch / clock.
// A prescaler produces a scan tick every CLK_FREQ/SCAN_HZ cycles; each tick
// advances the digit index and registers new fnd_com/fnd_data. Inputs are
// snapshotted once per frame (on the 3 -> 0 wrap) so a frame never tears.
// Optional build macro FND_DOT_BLINK_EN: lights the dp on digit 2 in the
// sec.msec view while the centisecond field is below 50.
module sw_fnd_ctrl
    import sw_fnd_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned SCAN_HZ  = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_sel,
    input  logic [6:0]            msec,
    input  logic [5:0]            sec,
    input  logic [5:0]            min,
    input  logic [4:0]            hour,
    output logic [NUM_DIGITS-1:0] fnd_com,
    output logic [7:0]            fnd_data
);

    localparam int unsigned DIV   = CLK_FREQ / SCAN_HZ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    digit_e                idx_q, idx_d;
    logic                  sel_q, sel_d;
    logic [6:0]            msec_q, msec_d;
    logic [5:0]            sec_q, sec_d;
    logic [5:0]            min_q, min_d;
    logic [4:0]            hour_q, hour_d;
    logic [NUM_DIGITS-1:0] com_q, com_d;
    logic [7:0]            data_q, data_d;
    logic                  tick;

    logic [6:0] lower, upper;
    logic [6:0] lo_tens, lo_ones, hi_tens, hi_ones;
    logic [3:0] digit_bcd;
    logic [6:0] digit_seg;
    logic       dp;

    // Prescaler, digit index and once-per-frame input snapshot
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        sel_d  = sel_q;
        msec_d = msec_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        tick   = (cnt_q == CNT_MAX);
        if (tick) begin
            cnt_d = '0;
            idx_d = digit_e'(idx_q + 2'd1);
            if (idx_q == DigHiTens) begin
                sel_d  = i_sel;
                msec_d = msec;
                sec_d  = sec;
                min_d  = min;
                hour_d = hour;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pick the digit for the index about to be shown, using the snapshot
    // that will be valid after this tick
    always_comb begin
        lower   = sat99(sel_d ? {1'b0, min_d} : msec_d);
        upper   = sat99(sel_d ? {2'b00, hour_d} : {1'b0, sec_d});
        lo_tens = lower / 7'd10;
        lo_ones = lower % 7'd10;
        hi_tens = upper / 7'd10;
        hi_ones = upper % 7'd10;
        digit_bcd = lo_ones[3:0];
        unique case (idx_d)
            DigLoOnes: digit_bcd = lo_ones[3:0];
            DigLoTens: digit_bcd = lo_tens[3:0];
            DigHiOnes: digit_bcd = hi_ones[3:0];
            DigHiTens: digit_bcd = hi_tens[3:0];
        endcase
`ifdef FND_DOT_BLINK_EN
        dp = ~((idx_d == DigHiOnes) && !sel_d && (lower < 7'd50));
`else
        dp = 1'b1;
`endif
    end

    sw_fnd_dec u_dec (
        .bcd_i (digit_bcd),
        .seg_o (digit_seg)
    );

    // Output registers only move on a tick; held otherwise
    always_comb begin
        com_d  = com_q;
        data_d = data_q;
        if (tick) begin
            com_d  = ~(NUM_DIGITS'(1) << idx_d);
            data_d = {dp, digit_seg};
        end
    end

    // State registers; reset leaves the display dark at index 3 so the
    // first tick wraps to digit 0 and takes a fresh snapshot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            idx_q  <= DigHiTens;
            sel_q  <= 1'b0;
            msec_q <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
            com_q  <= '1;
            data_q <= FND_OFF;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            sel_q  <= sel_d;
            msec_q <= msec_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            com_q  <= com_d;
            data_q <= data_d;
        end
    end

    assign fnd_com  = com_q;
    assign fnd_data = data_q;

endmodule

// File: tb/tb_sw_fnd_ctrl.sv
// Scoreboard bench for sw_fnd_ctrl with DIV = 10 (CLK_FREQ 1000, SCAN_HZ 100).
// Stimulus pushes hand-computed {fnd_com, fnd_data} per expected tick; a
// monitor pops and compares each time fnd_com changes.
module tb_sw_fnd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_sel = 1'b0;
    logic [6:0] msec = '0;
    logic [5:0] sec = '0;
    logic [5:0] min = '0;
    logic [4:0] hour = '0;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    sw_fnd_ctrl #(
        .CLK_FREQ (1000),
        .SCAN_HZ  (100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_sel    (i_sel),
        .msec     (msec),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .fnd_com  (fnd_com),
        .fnd_data (fnd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] com;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

`ifdef FND_DOT_BLINK_EN
    localparam logic [7:0] DIG2_MS30 = 8'h12;
`else
    localparam logic [7:0] DIG2_MS30 = 8'h92;
`endif

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got com/data %h, expected %h", name, act, req);
    endtask

    task automatic push(input string tag, input logic [3:0] com, input logic [7:0] data);
        exp_t e;
        e.tag  = tag;
        e.com  = com;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) until at most n expectations remain outstanding
    task automatic wait_qsize(input int n, input string tag);
        int cyc = 0;
        while (exp_q.size() > n && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        if (exp_q.size() > n) begin
            n_checks++;
            $display("FAIL %s: timeout with %0d entries pending, expected at most %0d",
                     tag, exp_q.size(), n);
            exp_q.delete();
        end
        #1;
    endtask

    // Release reset, confirm 9 dark cycles, then digit 0 lights on the 10th
    task automatic release_and_check(input string tag);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check($sformatf("%s_dark_c%0d", tag, i), {fnd_com, fnd_data}, {4'hF, 8'hFF});
        end
        @(negedge clk);
        check({tag, "_first_tick_com"}, {fnd_com, 8'h00}, {4'hE, 8'h00});
    endtask

    // Monitor: every fnd_com change is one displayed digit
    logic [3:0] prev_com = 4'hF;
    logic [7:0] prev_data = 8'hFF;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_com  = 4'hF;
                prev_data = 8'hFF;
            end else if (fnd_com !== prev_com) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_update", {fnd_com, fnd_data}, {prev_com, prev_data});
                end else begin
                    e = exp_q.pop_front();
                    check(e.tag, {fnd_com, fnd_data}, {e.com, e.data});
                end
                prev_com  = fnd_com;
                prev_data = fnd_data;
            end else if (fnd_data !== prev_data) begin
                check("hold_between_ticks", {fnd_com, fnd_data}, {prev_com, prev_data});
                prev_data = fnd_data;
            end
        end
    end

    initial begin
        // Reset state, view 0 with sec=42 msec=7
        i_sel = 1'b0;
        sec   = 6'd42;
        msec  = 7'd7;
        repeat (3) @(posedge clk);
        #1 check("reset_state", {fnd_com, fnd_data}, {4'hF, 8'hFF});

        for (int f = 0; f < 2; f++) begin
            push($sformatf("v0_f%0d_d0", f), 4'hE, 8'hF8);
            push($sformatf("v0_f%0d_d1", f), 4'hD, 8'hC0);
            push($sformatf("v0_f%0d_d2", f), 4'hB, 8'hA4);
            push($sformatf("v0_f%0d_d3", f), 4'h7, 8'h99);
        end
        release_and_check("rst1");
        wait_qsize(0, "drain_v0");

        // View 1, hour=23 min=59; min changes mid-frame without tearing
        i_sel = 1'b1;
        hour  = 5'd23;
        min   = 6'd59;
        push("v1_d0", 4'hE, 8'h90);
        push("v1_d1", 4'hD, 8'h92);
        push("v1_d2", 4'hB, 8'hB0);
        push("v1_d3", 4'h7, 8'hA4);
        wait_qsize(3, "v1_first_digit");
        min = 6'd0;
        push("v1_min0_d0", 4'hE, 8'hC0);
        push("v1_min0_d1", 4'hD, 8'hC0);
        push("v1_min0_d2", 4'hB, 8'hB0);
        push("v1_min0_d3", 4'h7, 8'hA4);
        wait_qsize(0, "drain_v1");

        // Saturation: msec=120 shows 99, dp stays off
        i_sel = 1'b0;
        msec  = 7'd120;
        sec   = 6'd5;
        push("sat_d0", 4'hE, 8'h90);
        push("sat_d1", 4'hD, 8'h90);
        push("sat_d2", 4'hB, 8'h92);
        push("sat_d3", 4'h7, 8'hC0);
        wait_qsize(0, "drain_sat");

        // msec=30: dp on digit 2 only when the blink option is built in
        msec = 7'd30;
        push("ms30_d0", 4'hE, 8'hC0);
        push("ms30_d1", 4'hD, 8'hB0);
        push("ms30_d2", 4'hB, DIG2_MS30);
        push("ms30_d3", 4'h7, 8'hC0);
        wait_qsize(0, "drain_ms30");

        // Reset mid-frame right after digit 2 is shown
        push("mid_d0", 4'hE, 8'hC0);
        push("mid_d1", 4'hD, 8'hB0);
        push("mid_d2", 4'hB, DIG2_MS30);
        wait_qsize(0, "drain_mid");
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("async_reset", {fnd_com, fnd_data}, {4'hF, 8'hFF});
        repeat (2) @(posedge clk);
        #1 check("held_in_reset", {fnd_com, fnd_data}, {4'hF, 8'hFF});

        push("rec_d0", 4'hE, 8'hC0);
        push("rec_d1", 4'hD, 8'hB0);
        push("rec_d2", 4'hB, DIG2_MS30);
        push("rec_d3", 4'h7, 8'hC0);
        release_and_check("rst2");
        wait_qsize(0, "drain_rec");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
